// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (F) and load/store (D).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   f_valid/f_addr/f_ready          fetch request channel
//   f_rvalid/f_rdata                fetch response (1-cycle pulse)
//   d_valid/d_we/d_addr/d_wdata     data request channel (d_we == 0 means load)
//   d_ready, d_rvalid/d_rdata       data accept strobe and response (loads and store acks)
//   flush                           pipeline redirect, squashes the in-flight fetch response
//   mem_req/mem_we/mem_addr/...     memory request side, held stable until mem_gnt
//   mem_gnt, mem_rvalid/mem_rdata   memory grant and response
//   busy                            a transaction is in flight
module mem_port_arbiter #(
  parameter int DWIDTH     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_valid,
  input  logic [DWIDTH-1:0] f_addr,
  output logic              f_ready,
  output logic              f_rvalid,
  output logic [DWIDTH-1:0] f_rdata,
  input  logic              d_valid,
  input  logic [3:0]        d_we,
  input  logic [DWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DWIDTH-1:0] d_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [DWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t            state_q;
  logic              own_d_q;
  logic              drop_q;
  logic [3:0]        streak_q;
  logic [3:0]        streak_d;
  logic [3:0]        we_q;
  logic [DWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              pick_d;
  logic              pick_f;
  logic              f_flush;
  logic              rsp;
  // D wins unless a waiting fetch has already seen MAX_STREAK data grants in a row
  assign pick_d   = state_q == IDLE && d_valid && !(f_valid && streak_q == 4'(MAX_STREAK));
  assign pick_f   = state_q == IDLE && f_valid && !pick_d;
  assign streak_d = (pick_d && f_valid) ? (streak_q == 4'(MAX_STREAK) ? streak_q : streak_q + 4'd1) : 4'd0;
  assign f_flush  = flush && !own_d_q;
  assign rsp      = state_q == RSP && mem_rvalid;
  assign f_ready  = rst_n && pick_f;
  assign d_ready  = rst_n && pick_d;
  // a squashed fetch is also suppressed if the redirect lands in the response cycle itself
  assign f_rvalid = rsp && !own_d_q && !drop_q && !flush;
  assign d_rvalid = rsp && own_d_q;
  assign f_rdata  = rst_n ? mem_rdata : '0;
  assign d_rdata  = rst_n ? mem_rdata : '0;
  assign mem_req  = state_q == REQ;
  assign mem_we   = we_q;
  assign mem_addr = addr_q & ~DWIDTH'(3);
  assign mem_wdata = wdata_q;
  assign busy     = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      own_d_q  <= 1'b0;
      drop_q   <= 1'b0;
      streak_q <= 4'd0;
      we_q     <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (pick_d || pick_f) begin
          state_q  <= REQ;
          own_d_q  <= pick_d;
          drop_q   <= pick_f && flush;
          streak_q <= streak_d;
          we_q     <= pick_d ? d_we : 4'd0;
          addr_q   <= pick_d ? d_addr : f_addr;
          wdata_q  <= pick_d ? d_wdata : '0;
        end
        REQ: begin
          state_q <= mem_gnt ? RSP : REQ;
          drop_q  <= drop_q || f_flush;
        end
        RSP: begin
          state_q <= mem_rvalid ? IDLE : RSP;
          drop_q  <= !mem_rvalid && (drop_q || f_flush);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int MAX = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_valid = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_ready, f_rvalid;
  logic [31:0] f_rdata;
  logic        d_valid = 1'b0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready, d_rvalid;
  logic [31:0] d_rdata;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  int total = 0;
  int bad = 0;
  // model: the single pending transaction, if any
  bit          m_busy, m_granted, m_own_d, m_drop;
  int          m_streak;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_we;
  bit          win_d, win_f;

  mem_port_arbiter #(.DWIDTH(32), .MAX_STREAK(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_granted = 0; m_own_d = 0; m_drop = 0; m_streak = 0;
    m_addr = '0; m_wdata = '0; m_we = '0;
  endtask

  task automatic compare();
    bit fr, dr;
    win_d = rst_n && !m_busy && d_valid && !(f_valid && m_streak >= MAX);
    win_f = rst_n && !m_busy && f_valid && !win_d;
    fr = rst_n && m_busy && m_granted && mem_rvalid && !m_own_d && !m_drop;
    dr = rst_n && m_busy && m_granted && mem_rvalid && m_own_d;
    chkb("f_ready", f_ready, win_f);
    chkb("d_ready", d_ready, win_d);
    chkb("mem_req", mem_req, m_busy && !m_granted);
    chkb("busy", busy, m_busy);
    chk("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
    chk("mem_we", {28'd0, mem_we}, {28'd0, m_we});
    chk("mem_wdata", mem_wdata, m_wdata);
    chkb("f_rvalid", f_rvalid, fr);
    chkb("d_rvalid", d_rvalid, dr);
    if (fr) chk("f_rdata", f_rdata, mem_rdata);
    if (dr) chk("d_rdata", d_rdata, mem_rdata);
  endtask

  task automatic update();
    if (!m_busy) begin
      if (win_d || win_f) begin
        m_busy = 1; m_granted = 0; m_own_d = win_d;
        m_addr = win_d ? d_addr : f_addr;
        m_we = win_d ? d_we : 4'd0;
        m_wdata = win_d ? d_wdata : 32'd0;
        m_drop = win_f && flush;
        m_streak = (win_d && f_valid) ? (m_streak < MAX ? m_streak + 1 : MAX) : 0;
      end
    end else if (!m_granted) begin
      if (mem_gnt) m_granted = 1;
      if (!m_own_d && flush) m_drop = 1;
    end else if (mem_rvalid) begin
      m_busy = 0; m_drop = 0;
    end else if (!m_own_d && flush) m_drop = 1;
  endtask

  task automatic cyc();
    #1 compare();
    @(posedge clk);
    if (rst_n) update();
    @(negedge clk);
  endtask

  task automatic serve(input logic [31:0] rd);
    mem_gnt = 1; cyc();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = rd; cyc();
    mem_rvalid = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    f_valid = 1; f_addr = 32'h44;
    #1 chkb("reset_busy", busy, 1'b0);
    chkb("reset_f_ready", f_ready, 1'b0);
    cyc();
    f_valid = 0; rst_n = 1;
    cyc();
    // lone fetch
    f_valid = 1; f_addr = 32'h1003;
    #1 chkb("lone_accept", f_ready, 1'b1);
    cyc();
    f_valid = 0; mem_gnt = 1;
    #1 chk("lone_addr", mem_addr, 32'h1000);
    chk("lone_we", {28'd0, mem_we}, 32'd0);
    cyc();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1 chkb("lone_rvalid", f_rvalid, 1'b1);
    chk("lone_rdata", f_rdata, 32'hDEADBEEF);
    cyc();
    mem_rvalid = 0;
    #1 chkb("lone_idle", busy, 1'b0);
    cyc();
    // simultaneous F and D: D first
    f_valid = 1; f_addr = 32'h40; d_valid = 1; d_we = 4'hF; d_addr = 32'h2000; d_wdata = 32'h12345678;
    #1 chkb("sim_d_first", d_ready, 1'b1);
    chkb("sim_f_wait", f_ready, 1'b0);
    cyc();
    d_valid = 0; mem_gnt = 1;
    #1 chk("sim_wdata", mem_wdata, 32'h12345678);
    chk("sim_we", {28'd0, mem_we}, 32'hF);
    cyc();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
    #1 chkb("sim_ack", d_rvalid, 1'b1);
    cyc();
    mem_rvalid = 0;
    #1 chkb("sim_f_next", f_ready, 1'b1);
    cyc();
    f_valid = 0;
    serve(32'h11112222);
    // anti-starvation: D,D,D,D,F,D
    f_valid = 1; f_addr = 32'h80; d_valid = 1; d_we = 4'h0; d_addr = 32'h3000;
    for (int i = 0; i < 6; i++) begin
      #1 chkb("streak_d", d_ready, i != 4);
      chkb("streak_f", f_ready, i == 4);
      cyc();
      serve(32'h100 + i);
    end
    f_valid = 0; d_valid = 0;
    cyc();
    // flush during RSP of a fetch with a late grant
    f_valid = 1; f_addr = 32'h300;
    cyc();
    f_valid = 0;
    repeat (3) cyc();
    mem_gnt = 1; cyc();
    mem_gnt = 0; flush = 1; cyc();
    flush = 0; mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
    #1 chkb("flush_drop", f_rvalid, 1'b0);
    chkb("flush_rsp_idle", busy, 1'b1);
    cyc();
    mem_rvalid = 0;
    d_valid = 1; d_we = 4'h0; d_addr = 32'h404;
    cyc();
    d_valid = 0; mem_gnt = 1; cyc();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    #1 chkb("flush_d_rvalid", d_rvalid, 1'b1);
    chk("flush_d_rdata", d_rdata, 32'hCAFEF00D);
    cyc();
    mem_rvalid = 0;
    // grant held low 5 cycles: payload stable, no readies
    d_valid = 1; d_we = 4'h3; d_addr = 32'h5006; d_wdata = 32'hA5A5A5A5;
    cyc();
    f_valid = 1; d_we = 4'h0; d_addr = 32'h9990; d_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1 chkb("hold_req", mem_req, 1'b1);
      chk("hold_addr", mem_addr, 32'h5004);
      chk("hold_wdata", mem_wdata, 32'hA5A5A5A5);
      chkb("hold_no_ready", f_ready || d_ready, 1'b0);
      cyc();
    end
    f_valid = 0; d_valid = 0;
    serve(32'h0);
    // reset while in REQ
    f_valid = 1; f_addr = 32'h700;
    cyc();
    #2 rst_n = 0;
    model_reset();
    #1 chkb("rst_req", mem_req, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chkb("rst_ready", f_ready, 1'b0);
    @(negedge clk);
    cyc();
    rst_n = 1; f_valid = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    #1 chkb("rst_spurious", f_rvalid, 1'b0);
    cyc();
    mem_rvalid = 0;
    #1 chkb("rst_idle", busy, 1'b0);
    cyc();
    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if (win_f) f_valid = 0;
      if (win_d) d_valid = 0;
      if (!f_valid && $urandom_range(2) == 0) begin f_valid = 1; f_addr = $urandom; end
      if (!d_valid && $urandom_range(2) == 0) begin
        d_valid = 1; d_addr = $urandom; d_wdata = $urandom;
        d_we = $urandom_range(1) == 0 ? 4'h0 : 4'($urandom);
      end
      mem_gnt = (m_busy && !m_granted) ? 1'($urandom_range(1)) : ($urandom_range(5) == 0);
      mem_rvalid = (m_busy && m_granted) ? 1'($urandom_range(1)) : ($urandom_range(5) == 0);
      mem_rdata = $urandom;
      flush = ($urandom_range(5) == 0) && !(m_busy && m_granted && mem_rvalid);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-ported unified memory between the instruction-fetch stage and the stage-3 load/store path of the 3-stage RISC-V core. It accepts one transaction at a time, sequences it through a request/grant/response handshake on the memory side, and routes the read data back to the owner. Data accesses win by default, bounded by a fetch anti-starvation counter. A pipeline redirect squashes in-flight fetch responses.

## Interface
- `DWIDTH`, 32, data and address width.
- `MAX_STREAK`, 4, consecutive data grants allowed while a fetch waits (1..15).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `f_valid`  in  1  fetch request pending.
- `f_addr`  in  DWIDTH  fetch byte address.
- `f_ready`  out  1  fetch request accepted this cycle.
- `f_rvalid`  out  1  fetch read data valid (1-cycle pulse).
- `f_rdata`  out  DWIDTH  fetch read data.
- `d_valid`  in  1  data request pending.
- `d_we`  in  4  byte write enables; 0 = load.
- `d_addr`  in  DWIDTH  data byte address.
- `d_wdata`  in  DWIDTH  store data.
- `d_ready`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data response valid (loads and store acks, 1-cycle pulse).
- `d_rdata`  out  DWIDTH  load data.
- `flush`  in  1  redirect pulse (stage-3 `pc_sel` != 0); squashes fetch.
- `mem_req`  out  1  memory request.
- `mem_we`  out  4  memory byte enables.
- `mem_addr`  out  DWIDTH  word-aligned address.
- `mem_wdata`  out  DWIDTH  write data.
- `mem_gnt`  in  1  memory accepted `mem_req`.
- `mem_rvalid`  in  1  memory response (one per accepted request).
- `mem_rdata`  in  DWIDTH  memory read data.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, REQ, RSP. Owner register `own` (F/D), drop flag `drop`, streak counter `streak` (4 bits).
- IDLE: if either valid, select winner combinationally, assert its `*_ready`, capture addr/we/wdata/owner, go REQ. Nothing pending: stay.
- Selection: D wins if `d_valid` unless `f_valid && streak == MAX_STREAK`; else F if `f_valid`.
- Streak: D grant with `f_valid`=1 -> `streak+1` (saturating at MAX_STREAK); any F grant -> 0; D grant with `f_valid`=0 -> 0.
- REQ: `mem_req`=1 with captured payload held stable; on `mem_gnt` go RSP.
- RSP: `mem_req`=0; on `mem_rvalid` pulse owner's `*_rvalid` combinationally with `*_rdata = mem_rdata`, go IDLE. If `own`=F and `drop`=1, no `f_rvalid`; `drop` cleared.
- `mem_addr = {addr[DWIDTH-1:2], 2'b00}`; F transactions drive `mem_we`=0, `mem_wdata`=0.
- Flush: sets `drop` when `own`=F in REQ/RSP, or when F is accepted in the same IDLE cycle. Never affects D transactions or `streak`. Flush in IDLE with no F accept: no effect.
- `mem_rvalid` outside RSP and `mem_gnt` outside REQ are ignored.
- `f_rdata`/`d_rdata` are don't-care when the matching rvalid is 0; drive `mem_rdata` to both.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `streak`=0, `drop`=0, captured payload 0; all outputs 0. Reset mid-transaction abandons it; no response forwarded afterwards.
- Accept cycle N (IDLE) -> `mem_req` high from N+1 until the gnt cycle inclusive -> response forwarded in the `mem_rvalid` cycle -> next accept earliest the following cycle.
- Minimum turnaround 3 cycles per transaction (gnt at N+1, rvalid at N+2, next accept N+3).
- `*_ready` asserted only in IDLE, at most one per cycle; requesters hold payload until ready.
- One outstanding transaction; no pipelining of requests.

## Test plan
- Lone fetch `f_addr`=0x1003, gnt same cycle as req, rvalid next with 0xDEADBEEF -> `mem_addr`=0x1000, `mem_we`=0, `f_rvalid` pulse with 0xDEADBEEF at cycle 2 after accept; `busy` low after.
- Simultaneous `f_valid` and `d_valid` (store `d_we`=0xF, 0x2000, 0x12345678) -> D accepted first, `d_rvalid` ack, then F accepted next IDLE cycle.
- `f_valid` held, `d_valid` held, MAX_STREAK=4 -> grants D,D,D,D,F,D...; `streak` returns to 0 after F.
- Fetch accepted, `flush` pulsed during RSP with gnt delayed 3 cycles -> `f_rvalid` never asserts; following D load returns data normally.
- `rst_n` asserted low while in REQ -> all outputs 0 immediately; spurious `mem_rvalid` after release ignored, state IDLE.
- `mem_gnt` held low 5 cycles -> `mem_req` and payload stable all 5 cycles; no `*_ready` asserted meanwhile.
